bcd_serial_adder: RTL and testbench
===================================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 The module SHALL have parameter DIGITS, default 4, giving the number of BCD digits per operand (legal range 1..16).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The module SHALL have port a, input, 4*DIGITS bits: augend/minuend, packed BCD, digit 0 in bits [3:0].
REQ-006 The module SHALL have port b, input, 4*DIGITS bits: addend/subtrahend, packed BCD.
REQ-007 The module SHALL have port cin, input, 1 bit: carry-in (add) or borrow-in (subtract).
REQ-008 The module SHALL have port sub, input, 1 bit: mode select, 1 = subtract; present only under BCD_SUB_EN.
REQ-009 The module SHALL have port sum, output, 4*DIGITS bits: packed BCD result.
REQ-010 The module SHALL have port cout, output, 1 bit: decimal carry-out (add) or no-borrow flag (subtract).
REQ-011 The module SHALL have port busy, output, 1 bit: operation in progress.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-013 The module SHALL have port err, output, 1 bit: at least one latched input digit exceeded 9.

Function
REQ-014 The FSM SHALL have states IDLE, ADD, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL latch a, b, cin and sub, clear the digit index and carry, and enter ADD.
REQ-016 In ADD, digit i SHALL be processed on the i-th ADD cycle, LSD first, one digit per cycle: the binary sum t = ai + bi' + carry, plus 6 if t > 9; the result digit is (corrected value mod 16) and carry = (t > 9).
REQ-017 After digit DIGITS-1, the FSM SHALL enter DONE; start accepted at edge k SHALL give done=1 in the cycle after edge k+DIGITS (latency DIGITS+1 edges).
REQ-018 busy SHALL be 1 exactly while in ADD; done SHALL be 1 exactly while in DONE (one cycle unless start re-arms).
REQ-019 DONE without start SHALL return to IDLE; DONE with start SHALL go directly to ADD (back-to-back, done still 1 that cycle).
REQ-020 start while in ADD SHALL be ignored; latched operands SHALL NOT change during ADD.
REQ-021 sum, cout and err SHALL hold their values from done until the next done; sum digits SHALL update in place during ADD.
REQ-022 err SHALL be 1 if any latched digit of a or b is greater than 9; the arithmetic per REQ-016 still completes and sum is undefined-but-deterministic.
REQ-023 Width boundary: the carry out of digit DIGITS-1 SHALL go to cout and SHALL NOT wrap into digit 0.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, sum=0, cout=0, busy=0, done=0, err=0, and clear internal registers, including mid-operation; no done SHALL follow an aborted operation.
REQ-025 On rst release, the first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-026 With macro BCD_SUB_EN defined, the sub port SHALL exist; sub=1 SHALL use bi' = 9 - bi and initial carry = ~cin, giving cout=1 when a >= b + cin (sum = a - b - cin) and otherwise the ten's-complement result with cout=0.
REQ-027 Without BCD_SUB_EN, the sub port SHALL be absent, bi' = bi, and initial carry = cin.

Verification (DIGITS=4)
REQ-028 a=0003, b=0003, cin=0 -> sum=0006, cout=0, done exactly 5 edges after start.
REQ-029 a=9999, b=0001, cin=0 -> sum=0000, cout=1; a=0047, b=0038, cin=1 -> sum=0086, cout=0.
REQ-030 a=00A0, b=0001 -> err=1 at done; the next operation with valid digits -> err=0.
REQ-031 Pulse start during busy with other operands -> ignored, original result returned; start held during DONE -> back-to-back operation, second done 5 edges later.
REQ-032 Assert rst during the 2nd ADD cycle -> all outputs 0 immediately, no done pulse, and a fresh start then completes correctly.
REQ-033 With BCD_SUB_EN: 0100-0001 -> 0099, cout=1; 0001-0002 -> 9999, cout=0.

Source files
------------

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, LSD first.
// Define BCD_SUB_EN to add the sub port and nine's-complement subtraction.
module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
`ifdef BCD_SUB_EN
    input  logic                  sub,
`endif
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] a_q, a_d;
    logic [4*DIGITS-1:0] b_q, b_d;
    logic [4*DIGITS-1:0] sum_q, sum_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                cout_q, cout_d;
    logic                err_q, err_d;
    logic                errp_q, errp_d;
    logic                sub_q, sub_d;
    logic                sub_in;

    logic [3:0] a_dig, b_dig, b_eff, res_dig;
    logic [4:0] t;
    logic       dig_carry;
    logic       in_bad;
    logic       last_dig;

`ifdef BCD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        // Nine's complement of the subtrahend digit; wraps mod 16 for invalid digits
        b_eff     = sub_q ? (4'd9 - b_dig) : b_dig;
        t         = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
        dig_carry = (t > 5'd9);
        res_dig   = dig_carry ? (t[3:0] + 4'd6) : t[3:0];
        last_dig  = (idx_q == IW'(DIGITS - 1));
    end

    always_comb begin
        in_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) in_bad = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        errp_d  = errp_q;
        sub_d   = sub_q;

        case (state_q)
            IDLE: ;
            ADD: begin
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) sum_d[4*i +: 4] = res_dig;
                end
                carry_d = dig_carry;
                idx_d   = idx_q + IW'(1);
                if (last_dig) begin
                    state_d = DONE;
                    cout_d  = dig_carry;
                    err_d   = errp_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (start && (state_q != ADD)) begin
            state_d = ADD;
            a_d     = a;
            b_d     = b;
            sub_d   = sub_in;
            carry_d = cin ^ sub_in;
            idx_d   = '0;
            errp_d  = in_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            errp_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            errp_q  <= errp_d;
            sub_q   <= sub_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;
    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (DIGITS=4); subtraction vectors run when BCD_SUB_EN is defined.
module tb_bcd_serial_adder;

    localparam int unsigned DIGITS = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout, busy, done, err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
        int          exp_cyc;
    } exp_t;

    exp_t sb[$];

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef BCD_SUB_EN
        .sub   (sub),
`endif
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc, e.exp_cyc);
                    chk("sum", {16'h0, sum}, {16'h0, e.sum});
                    chk("cout", {31'h0, cout}, {31'h0, e.cout});
                    chk("err", {31'h0, err}, {31'h0, e.err});
                end
            end else if (sb.size() != 0 && cyc > sb[0].exp_cyc) begin
                e = sb.pop_front();
                chk("missing_done", 32'd0, 32'd1);
            end
        end
    end

    // Called 1 unit after an edge with the DUT idle or in DONE.
    task automatic op(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic sv,
                      input logic [15:0] es, input logic ec, input logic ee);
        exp_t e;
        a = av; b = bv; cin = cv; sub = sv;
        start = 1'b1;
        e.sum = es; e.cout = ec; e.err = ee;
        e.exp_cyc = cyc + 1 + int'(DIGITS);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {31'h0, busy}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum",  {16'h0, sum}, 32'd0);
        chk("rst_cout", {31'h0, cout}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_err",  {31'h0, err}, 32'd0);
        rst = 1'b0;

        op(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0); drain();
        op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); drain();
        op(16'h0047, 16'h0038, 1'b1, 1'b0, 16'h0086, 1'b0, 1'b0); drain();
        op(16'h5000, 16'h5000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); drain();
        op(16'h9999, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0); drain();
        op(16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b1); drain();
        op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0); drain();

        // start pulsed mid-operation with other operands must be ignored
        op(16'h0012, 16'h0034, 1'b0, 1'b0, 16'h0046, 1'b0, 1'b0);
        @(posedge clk); #1;
        a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();

        // start held in the DONE cycle: back-to-back operation
        op(16'h0250, 16'h0250, 1'b0, 1'b0, 16'h0500, 1'b0, 1'b0);
        repeat (DIGITS) @(posedge clk);
        #1;
        chk("b2b_done_high", {31'h0, done}, 32'd1);
        op(16'h0808, 16'h0191, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        drain();

        // reset in the 2nd ADD cycle, with err and sum previously nonzero
        op(16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b1); drain();
        op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_sum",  {16'h0, sum}, 32'd0);
        chk("abort_cout", {31'h0, cout}, 32'd0);
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_done", {31'h0, done}, 32'd0);
        chk("abort_err",  {31'h0, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        op(16'h0345, 16'h0655, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0); drain();

`ifdef BCD_SUB_EN
        op(16'h0100, 16'h0001, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b0); drain();
        op(16'h0001, 16'h0002, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0); drain();
        op(16'h0050, 16'h0020, 1'b1, 1'b1, 16'h0029, 1'b1, 1'b0); drain();
`endif

        repeat (10) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
